// File: rtl/uxn_control_fsm_pkg.sv
// Shared opcode values, FSM state encodings and the opcode classifier for the uxn control unit.
package uxn_pkg;

   localparam int unsigned UXN_INSTR_W = 18;
   localparam int unsigned OP_MSB      = 17;
   localparam int unsigned OP_LSB      = 10;
   localparam int unsigned RA_MSB      = 9;
   localparam int unsigned RA_LSB      = 5;
   localparam int unsigned RB_MSB      = 4;
   localparam int unsigned RB_LSB      = 0;

   localparam logic [7:0] OP_ADD   = 8'h01;
   localparam logic [7:0] OP_SUB   = 8'h02;
   localparam logic [7:0] OP_MUL   = 8'h03;
   localparam logic [7:0] OP_DIV   = 8'h04;
   localparam logic [7:0] OP_MOD   = 8'h05;
   localparam logic [7:0] OP_AND   = 8'h10;
   localparam logic [7:0] OP_OR    = 8'h11;
   localparam logic [7:0] OP_XOR   = 8'h12;
   localparam logic [7:0] OP_SHL   = 8'h13;
   localparam logic [7:0] OP_LOAD  = 8'h20;
   localparam logic [7:0] OP_STORE = 8'h21;
   localparam logic [7:0] OP_JUMP  = 8'h30;
   localparam logic [7:0] OP_JZ    = 8'h31;
   localparam logic [7:0] OP_JNZ   = 8'h32;
   localparam logic [7:0] OP_NOP   = 8'h60;
   localparam logic [7:0] OP_HLT   = 8'h70;

   localparam logic [2:0] ST_INIT      = 3'd0;
   localparam logic [2:0] ST_FETCH     = 3'd1;
   localparam logic [2:0] ST_DECODE    = 3'd2;
   localparam logic [2:0] ST_EXECUTE   = 3'd3;
   localparam logic [2:0] ST_MEMORY    = 3'd4;
   localparam logic [2:0] ST_WRITEBACK = 3'd5;
   localparam logic [2:0] ST_HALT      = 3'd6;

   typedef enum logic [3:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_JUMP,
      CLS_JZ,
      CLS_JNZ,
      CLS_NOP,
      CLS_HLT,
      CLS_ILLEGAL
   } op_class_e;

   function automatic op_class_e uxn_decode(input logic [7:0] op);
      op_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
         OP_AND, OP_OR, OP_XOR, OP_SHL: cls = CLS_ALU;
         OP_LOAD:  cls = CLS_LOAD;
         OP_STORE: cls = CLS_STORE;
         OP_JUMP:  cls = CLS_JUMP;
         OP_JZ:    cls = CLS_JZ;
         OP_JNZ:   cls = CLS_JNZ;
         OP_NOP:   cls = CLS_NOP;
         OP_HLT:   cls = CLS_HLT;
         default:  cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/uxn_control_fsm_if.sv
// Unified memory req/ack bus between the uxn control unit (master) and memory (slave).
interface uxn_control_fsm_if #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned INSTR_W = 18
);
   logic               mem_req;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/uxn_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the uxn core: drives memory,
// register-file write port and the shared ALU.
module uxn_control_fsm
   import uxn_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 18,
   parameter int unsigned DATA_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   uxn_control_fsm_if.master  mem,
   input  logic [DATA_W-1:0]  rf_rdata_a,
   input  logic [DATA_W-1:0]  rf_rdata_b,
   output logic               rf_we,
   output logic [4:0]         rf_waddr,
   output logic               rf_wsel,
   output logic [7:0]         alu_op,
   output logic               alu_start,
   input  logic               alu_done,
   input  logic               alu_zero,
   output logic [INSTR_W-1:0] ir,
   output logic [ADDR_W-1:0]  pc,
   output logic [2:0]         state,
   output logic               halted,
   output logic               illegal
);

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               zflag_q, zflag_d;
   logic               alu_busy_q, alu_busy_d;
   logic               wsel_q, wsel_d;

   op_class_e          cls;
   logic [4:0]         ra, rb;
   logic [ADDR_W-1:0]  jump_tgt;

   assign ra       = ir_q[RA_MSB:RA_LSB];
   assign rb       = ir_q[RB_MSB:RB_LSB];
   assign cls      = uxn_decode(ir_q[OP_MSB:OP_LSB]);
   assign jump_tgt = {{(ADDR_W-10){1'b0}}, ra, rb};

   assign ir       = ir_q;
   assign pc       = pc_q;
   assign state    = state_q;
   assign alu_op   = ir_q[OP_MSB:OP_LSB];
   assign rf_waddr = ra;
   assign rf_wsel  = wsel_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      zflag_d       = zflag_q;
      alu_busy_d    = alu_busy_q;
      wsel_d        = wsel_q;
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = pc_q;
      mem.mem_wdata = rf_rdata_a;
      rf_we         = 1'b0;
      alu_start     = 1'b0;
      halted        = 1'b0;
      illegal       = 1'b0;

      case (state_q)
         ST_INIT: state_d = ST_FETCH;

         ST_FETCH: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ack) begin
               ir_d    = mem.mem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            state_d = ST_FETCH;
            case (cls)
               CLS_ALU: begin
                  alu_busy_d = 1'b0;
                  state_d    = ST_EXECUTE;
               end
               CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
               CLS_JUMP: pc_d = jump_tgt;
               CLS_JZ:   if (zflag_q)  pc_d = jump_tgt;
               CLS_JNZ:  if (!zflag_q) pc_d = jump_tgt;
               CLS_NOP:  ;
               CLS_HLT:  state_d = ST_HALT;
               default:  illegal = 1'b1;
            endcase
         end

         // alu_busy marks that the launch pulse has gone out; done may coincide with it
         ST_EXECUTE: begin
            alu_start  = !alu_busy_q;
            alu_busy_d = 1'b1;
            if (alu_done) begin
               zflag_d = alu_zero;
               wsel_d  = 1'b0;
               state_d = ST_WRITEBACK;
            end
         end

         ST_MEMORY: begin
            mem.mem_req  = 1'b1;
            mem.mem_we   = (cls == CLS_STORE);
            mem.mem_addr = rf_rdata_b[ADDR_W-1:0];
            if (mem.mem_ack) begin
               if (cls == CLS_STORE) begin
                  state_d = ST_FETCH;
               end else begin
                  wsel_d  = 1'b1;
                  state_d = ST_WRITEBACK;
               end
            end
         end

         ST_WRITEBACK: begin
            rf_we   = 1'b1;
            state_d = ST_FETCH;
         end

         ST_HALT: halted = 1'b1;

         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         pc_q       <= '0;
         ir_q       <= '0;
         zflag_q    <= 1'b0;
         alu_busy_q <= 1'b0;
         wsel_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         zflag_q    <= zflag_d;
         alu_busy_q <= alu_busy_d;
         wsel_q     <= wsel_d;
      end
   end

endmodule

// File: tb/tb_uxn_control_fsm.sv
// Instruction-level reference model of the uxn control unit; expands each instruction
// into its expected cycle timeline and compares every DUT output on every cycle.
module tb_uxn_control_fsm;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned INSTR_W = 18;

   localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                          S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uxn_control_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_W(INSTR_W)) mem_bus ();

   logic [DATA_W-1:0]  rf_rdata_a, rf_rdata_b;
   logic               rf_we, rf_wsel, alu_start, alu_done, alu_zero, halted, illegal;
   logic [4:0]         rf_waddr;
   logic [7:0]         alu_op;
   logic [INSTR_W-1:0] ir;
   logic [ADDR_W-1:0]  pc;
   logic [2:0]         state;

   uxn_control_fsm #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .mem(mem_bus.master),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel),
      .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done), .alu_zero(alu_zero),
      .ir(ir), .pc(pc), .state(state), .halted(halted), .illegal(illegal)
   );

   int vectors = 0;
   int miscompares = 0;

   // architectural model
   logic [15:0] m_pc;
   logic [17:0] m_ir;
   logic        m_z;
   int          m_alu_cnt = 0, m_wb_cnt = 0;
   int          n_starts = 0, n_rfwe = 0;

   // expected outputs and planned inputs for the current cycle
   logic [2:0]  e_state;
   logic        e_req, e_we, e_rfwe, e_wsel, e_start, e_halt, e_ill;
   logic [15:0] e_addr, e_wdata;
   logic [4:0]  e_waddr;
   logic        d_rst, d_ack, d_done, d_zero;
   logic [17:0] d_rdata;
   logic [15:0] d_a, d_b;

   always @(posedge clk) begin
      if (alu_start === 1'b1) n_starts++;
      if (rf_we === 1'b1) n_rfwe++;
   end

   function automatic bit is_alu(input logic [7:0] op);
      return (op >= 8'h01 && op <= 8'h05) || (op >= 8'h10 && op <= 8'h13);
   endfunction

   function automatic bit is_legal(input logic [7:0] op);
      return is_alu(op) || (op inside {8'h20, 8'h21, 8'h30, 8'h31, 8'h32, 8'h60, 8'h70});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic dflt(input logic [2:0] st);
      e_state = st; e_req = 0; e_we = 0; e_rfwe = 0; e_wsel = 0; e_start = 0;
      e_halt = 0; e_ill = 0; e_addr = '0; e_wdata = '0; e_waddr = '0;
      d_rst = 0; d_ack = 0; d_done = 0; d_zero = 1'($urandom); d_rdata = 18'($urandom);
   endtask

   task automatic cyc();
      @(negedge clk);
      rst = d_rst;
      mem_bus.mem_ack = d_ack; mem_bus.mem_rdata = d_rdata;
      alu_done = d_done; alu_zero = d_zero;
      rf_rdata_a = d_a; rf_rdata_b = d_b;
      #1;
      chk("state", 32'(state), 32'(e_state));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("alu_op", 32'(alu_op), 32'(m_ir[17:10]));
      chk("mem_req", 32'(mem_bus.mem_req), 32'(e_req));
      if (e_req) begin
         chk("mem_we", 32'(mem_bus.mem_we), 32'(e_we));
         chk("mem_addr", 32'(mem_bus.mem_addr), 32'(e_addr));
         if (e_we) chk("mem_wdata", 32'(mem_bus.mem_wdata), 32'(e_wdata));
      end
      chk("rf_we", 32'(rf_we), 32'(e_rfwe));
      if (e_rfwe) begin
         chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
         chk("rf_wsel", 32'(rf_wsel), 32'(e_wsel));
      end
      chk("alu_start", 32'(alu_start), 32'(e_start));
      chk("halted", 32'(halted), 32'(e_halt));
      chk("illegal", 32'(illegal), 32'(e_ill));
      if (miscompares > 200) begin
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
   endtask

   task automatic fetch_wait(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         dflt(S_FETCH); e_req = 1; e_addr = m_pc; cyc();
      end
   endtask

   task automatic reset_cycles(input int unsigned n);
      m_pc = '0; m_ir = '0; m_z = 0;
      for (int unsigned i = 0; i < n; i++) begin
         dflt(S_INIT); d_rst = 1; d_ack = 1; cyc();
      end
      dflt(S_INIT); cyc();
   endtask

   task automatic do_instr(input logic [7:0] op, input logic [4:0] ra, input logic [4:0] rb,
                           input int unsigned fw, input int unsigned aw, input int unsigned dw,
                           input logic az, input logic [15:0] a, input logic [15:0] b);
      logic [17:0] w;
      logic [15:0] tgt;
      w = {op, ra, rb};
      tgt = {6'd0, ra, rb};
      d_a = a; d_b = b;
      for (int unsigned i = 0; i <= fw; i++) begin
         dflt(S_FETCH); e_req = 1; e_addr = m_pc;
         if (i == fw) begin d_ack = 1; d_rdata = w; end
         cyc();
      end
      m_pc = m_pc + 16'd1;
      m_ir = w;
      dflt(S_DECODE); e_ill = !is_legal(op); cyc();
      if (is_alu(op)) begin
         m_alu_cnt++;
         for (int unsigned i = 0; i <= aw; i++) begin
            dflt(S_EXEC); e_start = (i == 0);
            if (i == aw) begin d_done = 1; d_zero = az; end
            cyc();
         end
         m_z = az;
         m_wb_cnt++;
         dflt(S_WB); e_rfwe = 1; e_waddr = ra; e_wsel = 0; cyc();
      end else if (op == 8'h20 || op == 8'h21) begin
         for (int unsigned i = 0; i <= dw; i++) begin
            dflt(S_MEM); e_req = 1; e_we = (op == 8'h21); e_addr = b; e_wdata = a;
            d_ack = (i == dw);
            cyc();
         end
         if (op == 8'h20) begin
            m_wb_cnt++;
            dflt(S_WB); e_rfwe = 1; e_waddr = ra; e_wsel = 1; cyc();
         end
      end else if (op == 8'h30 || (op == 8'h31 && m_z) || (op == 8'h32 && !m_z)) begin
         m_pc = tgt;
      end else if (op == 8'h70) begin
         for (int unsigned i = 0; i < 100; i++) begin
            dflt(S_HALT); e_halt = 1; cyc();
         end
      end
   endtask

   logic [7:0] legal_ops [15] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11, 8'h12,
                                  8'h13, 8'h20, 8'h21, 8'h30, 8'h31, 8'h32, 8'h60};

   initial begin
      logic [7:0] op;
      rst = 1; mem_bus.mem_ack = 0; mem_bus.mem_rdata = '0;
      alu_done = 0; alu_zero = 0; rf_rdata_a = '0; rf_rdata_b = '0;
      d_a = '0; d_b = '0;
      reset_cycles(3);

      do_instr(8'h01, 5'd1, 5'd1, 0, 1, 0, 1'b0, 16'd1, 16'd1);
      chk("pin_add_pc", 32'(m_pc), 32'h1);
      do_instr(8'h01, 5'd2, 5'd3, 0, 0, 0, 1'b0, 16'h1234, 16'h0001);
      do_instr(8'h04, 5'd6, 5'd3, 1, 8, 0, 1'b0, 16'd100, 16'd7);
      do_instr(8'h02, 5'd4, 5'd4, 0, 0, 0, 1'b1, 16'h0005, 16'h0005);
      do_instr(8'h31, 5'd2, 5'd3, 0, 0, 0, 1'b0, 16'h0, 16'h0);
      chk("pin_jz_taken", 32'(m_pc), 32'h0043);
      do_instr(8'h02, 5'd4, 5'd5, 2, 0, 0, 1'b0, 16'h0007, 16'h0005);
      do_instr(8'h31, 5'd2, 5'd3, 0, 0, 0, 1'b0, 16'h0, 16'h0);
      chk("pin_jz_fall", 32'(m_pc), 32'h0045);
      do_instr(8'h21, 5'd9, 5'd10, 0, 0, 3, 1'b0, 16'hBEEF, 16'h0100);
      do_instr(8'h22, 5'd1, 5'd2, 0, 0, 0, 1'b0, 16'h0, 16'h0);
      do_instr(8'h20, 5'd7, 5'd8, 1, 0, 1, 1'b0, 16'h0, 16'h0200);
      do_instr(8'h30, 5'd31, 5'd31, 0, 0, 0, 1'b0, 16'h0, 16'h0);
      chk("pin_jump", 32'(m_pc), 32'h03FF);
      do_instr(8'h02, 5'd0, 5'd0, 0, 2, 0, 1'b1, 16'h0, 16'h0);
      do_instr(8'h60, 5'd0, 5'd0, 0, 0, 0, 1'b0, 16'h0, 16'h0);

      // reset in the middle of a fetch handshake clears the latched zero flag too
      fetch_wait(2);
      reset_cycles(2);
      do_instr(8'h32, 5'd0, 5'd5, 0, 0, 0, 1'b0, 16'h0, 16'h0);
      chk("pin_jnz_after_reset", 32'(m_pc), 32'h0005);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            op = 8'($urandom);
            if (op == 8'h70) op = 8'h23;
         end else begin
            op = legal_ops[$urandom_range(0, 14)];
         end
         do_instr(op, 5'($urandom), 5'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 2),
                  $urandom_range(0, 3), 1'($urandom), 16'($urandom), 16'($urandom));
      end

      do_instr(8'h70, 5'd0, 5'd0, 1, 0, 0, 1'b0, 16'h0, 16'h0);
      chk("alu_start_count", 32'(n_starts), 32'(m_alu_cnt));
      chk("rf_we_count", 32'(n_rfwe), 32'(m_wb_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
